fetch_unit: RTL and testbench

Instruction fetch stage that produces the `pc`/`inst` pair consumed by the IF/ID pipeline register. It owns the program counter and issues one instruction-memory request at a time over a request/grant, response-valid handshake. It presents each fetched word with its PC on a registered output. It honours decode-side stall and branch/jump redirect (flush), inserting NOP bubbles where no valid instruction exists.

---
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and single-outstanding instruction fetch with stall buffer and redirect flush
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic                  valid_o
);
    typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;
    state_t state, state_next;
    logic [DATA_WIDTH-1:0] fetch_pc, req_pc, buf_pc, buf_inst;
    logic buf_valid, accept, resp;
    assign accept = imem_req_o && imem_gnt_i;
    assign resp   = (state == WAIT) && imem_rvalid_i;
    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_next;
    end
    // next state: a redirect while waiting turns the in-flight response into one to discard
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? WAIT : IDLE;
            WAIT:    state_next = imem_rvalid_i ? IDLE : (redirect_i ? KILL : WAIT);
            KILL:    state_next = imem_rvalid_i ? IDLE : KILL;
            default: state_next = IDLE;
        endcase
    end
    // request side: issue only when idle, nothing buffered and no redirect this cycle
    always_comb begin
        imem_req_o  = (state == IDLE) && !buf_valid && !redirect_i;
        imem_addr_o = fetch_pc;
    end
    // fetch address and address of the outstanding request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        end else if (accept) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + DATA_WIDTH'(4);
        end
    end
    // one-entry buffer catches a response that arrives while stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_inst  <= '0;
        end else if (redirect_i || !stall_i) begin
            buf_valid <= 1'b0;
        end else if (resp) begin
            buf_valid <= 1'b1;
            buf_pc    <= req_pc;
            buf_inst  <= imem_rdata_i;
        end
    end
    // output register: buffer first, then a fresh response, otherwise a bubble
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_o    <= '0;
            inst_o  <= NOP_INST;
            valid_o <= 1'b0;
        end else if (redirect_i || (!stall_i && !buf_valid && !resp)) begin
            pc_o    <= '0;
            inst_o  <= NOP_INST;
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            pc_o    <= buf_valid ? buf_pc : req_pc;
            inst_o  <= buf_valid ? buf_inst : imem_rdata_i;
            valid_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based fetch model checked every cycle
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0, rst_n = 1'b1, stall = 1'b0, redirect = 1'b0, gnt = 1'b1, rvalid = 1'b0;
    logic [31:0] redirect_pc = '0, rdata = '0;
    logic req, valid;
    logic [31:0] addr, pc, inst;
    logic req2, valid2, rvalid2 = 1'b0;
    logic [31:0] addr2, pc2, inst2;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .pc_o(pc), .inst_o(inst), .valid_o(valid)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_gnt_i(1'b1), .imem_rvalid_i(rvalid2), .imem_rdata_i(32'hABCD_0000),
        .pc_o(pc2), .inst_o(inst2), .valid_o(valid2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: next fetch address, in-flight request, discard flag, stall queue, expected outputs
    logic [31:0] m_fetch, m_ifpc, e_pc, e_inst;
    logic m_busy, m_drop, e_valid, er, got, keep;
    logic [63:0] q[$];
    logic [63:0] pr;
    // memory environment
    int lat = 1, mem_cnt = 0;
    logic mem_busy = 1'b0, rv_n = 1'b0, acc2 = 1'b0;
    logic [31:0] mem_addr = '0;
    // per-cycle log for literal checks
    logic [31:0] log_pc[64], log_inst[64], log_addr[64];
    logic log_valid[64], log_req[64];
    int cyc = 0, scyc = 0;
    logic [31:0] q2[$];
    logic seen2 = 1'b0;
    logic [31:0] first_pc2 = '0, first_inst2 = '0;

    // compare DUT against model, then advance model and memory by one clock
    always @(negedge clk) begin
        if (!rst_n) begin
            m_fetch = 32'h0; m_ifpc = 32'h0; m_busy = 1'b0; m_drop = 1'b0;
            q.delete();
            e_pc = 32'h0; e_inst = NOP; e_valid = 1'b0;
            mem_busy = 1'b0; rv_n = 1'b0; acc2 = 1'b0; cyc = 0;
        end else begin
            chk("pc_o", pc, e_pc);
            chk("inst_o", inst, e_inst);
            chk("valid_o", {31'b0, valid}, {31'b0, e_valid});
            er = !m_busy && q.size() == 0 && !redirect;
            chk("imem_req_o", {31'b0, req}, {31'b0, er});
            chk("imem_addr_o", addr, m_fetch);
            chk("no_resp_while_buffered", {31'b0, dut.buf_valid && rvalid}, 32'h0);
            if (cyc < 64) begin
                log_pc[cyc] = pc; log_inst[cyc] = inst; log_addr[cyc] = addr;
                log_valid[cyc] = valid; log_req[cyc] = req;
            end
            got  = m_busy && rvalid;
            keep = got && !m_drop && !redirect;
            pr   = {m_ifpc, rdata};
            if (got) begin m_busy = 1'b0; m_drop = 1'b0; end
            if (redirect) begin
                if (m_busy) m_drop = 1'b1;
                m_fetch = {redirect_pc[31:2], 2'b00};
                q.delete();
                e_pc = 32'h0; e_inst = NOP; e_valid = 1'b0;
            end else begin
                if (er && gnt) begin m_busy = 1'b1; m_ifpc = m_fetch; m_fetch = m_fetch + 32'd4; end
                if (!stall) begin
                    if (q.size() > 0) begin pr = q.pop_front(); keep = 1'b1; end
                    if (keep) begin e_pc = pr[63:32]; e_inst = pr[31:0]; e_valid = 1'b1; end
                    else begin e_pc = 32'h0; e_inst = NOP; e_valid = 1'b0; end
                end else if (keep) q.push_back(pr);
            end
            if (rvalid) mem_busy = 1'b0;
            else if (mem_busy && mem_cnt > 1) mem_cnt--;
            if (req && gnt) begin mem_busy = 1'b1; mem_cnt = lat; mem_addr = addr; end
            rv_n = mem_busy && mem_cnt == 1;
            acc2 = req2;
            if (req2 && q2.size() < 2) q2.push_back(addr2);
            if (valid2 && !seen2) begin seen2 = 1'b1; first_pc2 = pc2; first_inst2 = inst2; end
            cyc++;
        end
    end

    // memory response drivers (data returned equals the address)
    always @(posedge clk) begin
        #1;
        rvalid  = rv_n;
        rdata   = mem_addr;
        rvalid2 = acc2;
    end

    task automatic to_cycle(input int k);
        while (scyc < k) begin
            @(posedge clk);
            #1;
            scyc++;
        end
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #1;
        chk("reset_pc_o", pc, 32'h0);
        chk("reset_inst_o", inst, NOP);
        chk("reset_valid_o", {31'b0, valid}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        scyc = 0;
        to_cycle(4);  stall = 1'b1;
        to_cycle(9);  stall = 1'b0;
        to_cycle(12); lat = 3;
        to_cycle(13); redirect = 1'b1; redirect_pc = 32'h100;
        to_cycle(14); redirect = 1'b0; lat = 1;
        to_cycle(19); redirect = 1'b1; redirect_pc = 32'h203; stall = 1'b1;
        to_cycle(20); redirect = 1'b0;
        to_cycle(21); stall = 1'b0;
        to_cycle(22); redirect = 1'b1; redirect_pc = 32'h20;
        to_cycle(23); redirect = 1'b0; gnt = 1'b0;
        to_cycle(26); gnt = 1'b1;
        to_cycle(28); lat = 3;
        to_cycle(29);
        chk("lit_first_req", {31'b0, log_req[0]}, 32'h1);
        chk("lit_first_addr", log_addr[0], 32'h0);
        chk("lit_bubble1_valid", {31'b0, log_valid[1]}, 32'h0);
        chk("lit_bubble1_inst", log_inst[1], NOP);
        chk("lit_c2_valid", {31'b0, log_valid[2]}, 32'h1);
        chk("lit_c2_pc", log_pc[2], 32'h0);
        chk("lit_c3_inst", log_inst[3], NOP);
        chk("lit_c4_pc", log_pc[4], 32'h4);
        chk("lit_stall_frozen_pc", log_pc[8], 32'h4);
        chk("lit_stall_frozen_inst", log_inst[8], 32'h4);
        chk("lit_stall_no_req", {31'b0, log_req[6]}, 32'h0);
        chk("lit_unstall_pc", log_pc[10], 32'h8);
        chk("lit_resume_addr", log_addr[10], 32'hC);
        chk("lit_kill_no_valid15", {31'b0, log_valid[15]}, 32'h0);
        chk("lit_kill_no_valid16", {31'b0, log_valid[16]}, 32'h0);
        chk("lit_redirect_req", {31'b0, log_req[16]}, 32'h1);
        chk("lit_redirect_addr", log_addr[16], 32'h100);
        chk("lit_redirect_first_pc", log_pc[18], 32'h100);
        chk("lit_redirect_first_valid", {31'b0, log_valid[18]}, 32'h1);
        chk("lit_drop_bubble_valid", {31'b0, log_valid[20]}, 32'h0);
        chk("lit_drop_bubble_inst", log_inst[20], NOP);
        chk("lit_drop_req_addr", log_addr[20], 32'h200);
        chk("lit_drop_req", {31'b0, log_req[20]}, 32'h1);
        for (int i = 23; i <= 26; i++) chk("lit_nogrant_addr", log_addr[i], 32'h20);
        chk("lit_nogrant_req", {31'b0, log_req[25]}, 32'h1);
        chk("lit_grant_advance", log_addr[27], 32'h24);
        chk("lit_grant_pc", log_pc[28], 32'h20);
        chk("wrap_req_count", q2.size(), 32'd2);
        chk("wrap_first_addr", q2.size() > 0 ? q2[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("wrap_second_addr", q2.size() > 1 ? q2[1] : 32'hDEAD_BEEF, 32'h0);
        chk("wrap_first_pc", first_pc2, 32'hFFFF_FFFC);
        chk("wrap_first_inst", first_inst2, 32'hABCD_0000);
        #2 rst_n = 1'b0;
        #1;
        chk("midwait_reset_pc_o", pc, 32'h0);
        chk("midwait_reset_inst_o", inst, NOP);
        chk("midwait_reset_valid_o", {31'b0, valid}, 32'h0);
        chk("midwait_reset_req", {31'b0, req}, 32'h1);
        chk("midwait_reset_addr", addr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1; lat = 1;
        scyc = 0;
        to_cycle(3);
        chk("restart_pc", log_pc[2], 32'h0);
        chk("restart_valid", {31'b0, log_valid[2]}, 32'h1);
        to_cycle(6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
